// File: rtl/spi_reg_writer.sv
// SPI mode-0 slave that turns host burst frames into single-cycle register-bank
// write strobes with an auto-incrementing, saturating 7-bit address.
module spi_reg_writer #(
    parameter int ADDR_WIDTH = 31,
    parameter int NUM_REGS   = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [7:0]            data_out,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DRAIN
    } state_t;

    logic [1:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_prev_q;
    logic       cs_prev_q;
    logic [1:0] settle_q;
    logic       armed_q;

    state_t                state_q;
    logic [2:0]            bit_cnt_q;
    logic [6:0]            shift_q;
    logic [6:0]            addr_cnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            data_q;
    logic                  busy_q;
    logic                  err_q;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sclk_rise;
    logic       cs_rise;
    logic       cs_fall;
    logic       last_bit;
    logic       in_range;
    logic [7:0] byte_d;
    logic [6:0] addr_inc_d;

    // NOTE: synchronizer flops reset to the bus idle levels (cs_n high, sclk and
    // mosi low) so that no spurious edge is seen on the first cycles after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            settle_q    <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            cs_sync_q   <= {cs_sync_q[0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sclk_prev_q <= sclk_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
            settle_q    <= {settle_q[0], 1'b1};
            // A frame already in progress at reset release stays ignored until
            // cs_n has genuinely been seen high once.
            armed_q     <= armed_q | (settle_q[1] & cs_sync_q[1]);
        end
    end

    assign sclk_s     = sclk_sync_q[1];
    assign cs_s       = cs_sync_q[1];
    assign mosi_s     = mosi_sync_q[1];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign cs_rise    = cs_s & ~cs_prev_q;
    assign cs_fall    = armed_q & cs_prev_q & ~cs_s;
    assign byte_d     = {shift_q, mosi_s};
    assign last_bit   = sclk_rise && (bit_cnt_q == 3'd7);
    assign in_range   = int'(addr_cnt_q) < NUM_REGS;
    assign addr_inc_d = (addr_cnt_q == 7'h7F) ? 7'h7F : addr_cnt_q + 7'd1;

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch reads the pre-edge values of the registers, independent of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            addr_cnt_q <= 7'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= 8'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            busy_q <= ~cs_s;
            if (cs_rise) begin
                // cs rise outranks a coincident sclk rise; a partial byte is dropped.
                state_q   <= S_IDLE;
                bit_cnt_q <= 3'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cs_fall) begin
                            bit_cnt_q <= 3'd0;
                            err_q     <= 1'b0;
                            state_q   <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (sclk_rise) begin
                            shift_q   <= byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                        if (last_bit) begin
                            if (byte_d[7]) begin
                                addr_cnt_q <= byte_d[6:0];
                                state_q    <= S_DATA;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                    S_DATA: begin
                        if (sclk_rise) begin
                            shift_q   <= byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                        if (last_bit) begin
                            if (in_range) begin
                                we_q   <= 1'b1;
                                addr_q <= ADDR_WIDTH'(addr_cnt_q);
                                data_q <= byte_d;
                            end else begin
                                err_q <= 1'b1;
                            end
                            addr_cnt_q <= addr_inc_d;
                        end
                    end
                    S_DRAIN: begin
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign we       = we_q;
    assign addr     = addr_q;
    assign data_out = data_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: doc/spi_reg_writer.md
# spi_reg_writer

SPI slave front end that lets the host controller program the equalizer register bank over a 4-wire SPI link. It deserializes host frames into single-cycle write strobes (`we`, `addr`, `data_out`) that connect directly to the register bank's `we`, `addr` and `data_in` ports. Burst writes auto-increment the address, so a single chip-select frame loads the configuration byte and all ten 24-bit gains.

## Interface

**Parameters**

- `ADDR_WIDTH`, 31: width of the `addr` output. Must equal the register bank's address port width.
- `NUM_REGS`, 31: number of writable byte registers. Valid addresses are 0..NUM_REGS-1.

**Ports**

- `clk`  in  1: system clock. Must run at ≥ 4× `sclk`.
- `rst`  in  1: asynchronous, active-low reset.
- `sclk`  in  1: SPI clock from the host, asynchronous to `clk`.
- `cs_n`  in  1: SPI chip select, active low, asynchronous.
- `mosi`  in  1: SPI serial data in, asynchronous.
- `we`  out  1: one-cycle write strobe.
- `addr`  out  ADDR_WIDTH: write address, zero-extended from 7 bits.
- `data_out`  out  8: write data byte.
- `busy`  out  1: high while a frame is active (synchronized `cs_n` low).
- `err`  out  1: sticky flag for an out-of-range write or a malformed frame in the current or last frame.

## Operation

- **Input synchronization:** `sclk`, `cs_n` and `mosi` each pass through a 2-FF synchronizer clocked by `clk`. After synchronization:
  - an sclk rise is sync `sclk`=1 with the previous value 0;
  - a cs fall / cs rise are detected the same way on sync `cs_n`.
- **Protocol:** SPI mode 0, MSB first. `mosi` is sampled on sclk rise.
- **Frame layout:**
  - Byte 0 is the command: bit7=1 means write; bits6:0 give the start address.
  - Bytes 1..n are data, written to start, start+1, and so on.
- **State machine:**
  - IDLE: on cs fall, clear the bit counter and clear `err`, then go to CMD.
  - CMD: shift in 8 bits. On the 8th bit:
    - if bit7=1, load the address counter with bits6:0 and go to DATA;
    - if bit7=0 (read, not supported), set `err` and go to DRAIN.
  - DATA: shift in 8 bits. On the 8th bit:
    - if the address counter < NUM_REGS, issue a write;
    - otherwise discard the byte and set `err`.
    - In both cases increment the address counter (7-bit, saturating at 127) and stay in DATA.
  - DRAIN: ignore all sclk edges until cs rise.
- **cs rise:** from any state, return to IDLE. A partial byte (1–7 bits) is discarded with no write; this is not an error.
- **Simultaneous events:** if cs rise and a sclk rise are seen in the same cycle, cs rise wins and the bit is dropped.
- **Output hold:** `addr` and `data_out` hold their last written values between strobes. They change only in the cycle `we` rises.
- **Frame boundaries:** `busy` follows sync `cs_n` inverted. `err` is cleared only at the next cs fall or by reset.
- **Reset:** `rst` low forces, asynchronously:
  - IDLE state;
  - `we`=0, `addr`=0, `data_out`=0, `busy`=0, `err`=0;
  - shift register and counters to 0;
  - synchronizer flops to idle levels: `cs_n`=1, `sclk`=0, `mosi`=0.

  A frame in progress when reset releases is ignored until the next cs fall.

## Timing

- Synchronizer latency is 2 `clk` cycles. The sclk-rise detect occurs in cycle T, the 3rd `clk` edge after the pin edge.
- The bit is shifted in during cycle T.
- When the bit in T is the 8th bit of a valid data byte, `we`=1 for exactly cycle T+1, with `addr` and `data_out` valid in that same cycle.
- Back-to-back strobes are separated by ≥ 8 sclk periods, i.e. ≥ 32 `clk` cycles.
- `busy` rises 3 cycles after the `cs_n` pin falls and drops 3 cycles after it rises.
- `err` asserts in cycle T+1 of the offending byte.
- No handshake back to the host. The register bank accepts every `we` unconditionally.

## Test plan

- **Single write:** cs low, send 0x85 then 0x3C, cs high → one `we` pulse with `addr`=5, `data_out`=0x3C, `err`=0.
- **Full burst:** send 0x80 then 31 bytes 0x01..0x1F → 31 `we` pulses on addr 0..30, data 0x01..0x1F, `err`=0, `busy` high throughout.
- **Out-of-range:** send 0x9E (start 30) then 0xAA, 0xBB → single write addr 30 = 0xAA; 0xBB discarded; `err`=1 after the 3rd byte; `err` clears at the next cs fall.
- **Abort and read command:**
  - send 0x81, 0x55, then 4 bits, then cs high → one write (addr 1 = 0x55), no further `we`, `err`=0;
  - a frame starting 0x01 then 0xFF → no `we`, `err`=1.
- **Reset mid-frame:** assert `rst` after 12 bits of a 0x82/0x77 frame → all outputs 0 immediately; after release, sclk edges before the next cs fall produce no `we`.
- **Clock ratio:** run with `clk` = exactly 4× `sclk` and random phase offset → every byte of a 10-byte burst is written correctly with no missed bits.
